hash_msg_feeder: RTL and testbench

//  Source side of the F_dr/F_rtr/End_of_File byte protocol consumed by the hash control FSM.

---
 rtl/hash_msg_feeder_pkg.sv | 14 +
 rtl/hash_msg_feeder_if.sv | 24 ++
 rtl/hash_msg_feeder_fifo.sv | 56 +++++
 rtl/hash_msg_feeder.sv | 123 ++++++++++++
 tb/tb_hash_msg_feeder.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hash_msg_feeder_pkg.sv
// Shared types and constants for the hash message feeder.
// Optional byte-length counter: HASH_FEED_LEN_CNT_EN (see hash_msg_feeder.sv).
package hash_feed_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    EOF  = 2'd2,
    DONE = 2'd3
  } feed_state_e;

endpackage

// File: rtl/hash_msg_feeder_if.sv
// Byte/digest link between the message feeder (master) and the hash core (slave).
interface hash_msg_feeder_if #(
  parameter int unsigned DIGEST_W = 32
);
  import hash_feed_pkg::*;

  logic                F_dr;
  logic [BYTE_W-1:0]   F_data;
  logic                F_rtr;
  logic                End_of_File;
  logic                H_ready;
  logic [DIGEST_W-1:0] digest_in;

  modport master (
    output F_dr, F_data, End_of_File,
    input  F_rtr, H_ready, digest_in
  );

  modport slave (
    input  F_dr, F_data, End_of_File,
    output F_rtr, H_ready, digest_in
  );

endinterface

// File: rtl/hash_msg_feeder_fifo.sv
// Show-ahead synchronous byte FIFO with synchronous flush.
// head always shows the oldest entry; it is meaningless while empty.
module hash_feed_fifo
  import hash_feed_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = BYTE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
    head    = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hash_msg_feeder.sv
// Message byte source for the hash control FSM: buffers upstream bytes, presents
// them over F_dr/F_rtr, raises End_of_File when exhausted and latches the digest.
// Define HASH_FEED_LEN_CNT_EN to enable the msg_len transfer counter.
module hash_msg_feeder
  import hash_feed_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIGEST_W   = 32,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_last,
  input  logic                msg_close,
  output logic                hash_start,
  hash_msg_feeder_if.master   hif,
  output logic [DIGEST_W-1:0] digest_out,
  output logic                digest_valid,
  output logic [LEN_W-1:0]    msg_len
);

  feed_state_e       state;
  feed_state_e       state_nxt;
  logic              closed;
  logic              go_acc;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_head;

  hash_feed_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_data),
    .pop   (pop),
    .flush (go_acc),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; all derive from registers only, so F_dr is glitch-free.
  always_comb begin
    state_nxt       = state;
    go_acc          = 1'b0;
    in_ready        = 1'b0;
    hif.F_dr        = 1'b0;
    hif.F_data      = '0;
    hif.End_of_File = 1'b0;
    case (state)
      IDLE: begin
        go_acc = go;
        if (go) state_nxt = FEED;
      end
      FEED: begin
        in_ready   = !fifo_full && !closed;
        hif.F_dr   = !fifo_empty;
        hif.F_data = fifo_empty ? '0 : fifo_head;
        if (closed && fifo_empty) state_nxt = EOF;
      end
      EOF: begin
        hif.End_of_File = 1'b1;
        if (hif.H_ready) state_nxt = DONE;
      end
      DONE: begin
        go_acc = go;
        if (go) state_nxt = FEED;
      end
      default: state_nxt = IDLE;
    endcase
    push = in_valid && in_ready;
    pop  = hif.F_dr && hif.F_rtr;
  end

  // Message control: start pulse, close flag and digest capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_start   <= 1'b0;
      closed       <= 1'b0;
      digest_valid <= 1'b0;
      digest_out   <= '0;
    end else begin
      hash_start <= go_acc;
      if (go_acc) begin
        closed       <= 1'b0;
        digest_valid <= 1'b0;
      end else begin
        if (state == FEED && ((push && in_last) || msg_close)) closed <= 1'b1;
        if (state == EOF && hif.H_ready) begin
          digest_valid <= 1'b1;
          digest_out   <= hif.digest_in;
        end
      end
    end
  end

`ifdef HASH_FEED_LEN_CNT_EN
  // Saturating count of bytes handed to the hash core this message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      msg_len <= '0;
    else if (go_acc)                 msg_len <= '0;
    else if (pop && (msg_len != '1)) msg_len <= msg_len + 1'b1;
  end
`else
  assign msg_len = '0;
`endif

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed self-checking bench for hash_msg_feeder.
module tb_hash_msg_feeder;
  import hash_feed_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        msg_close;
  logic        hash_start;
  logic [31:0] digest_out;
  logic        digest_valid;
  logic [15:0] msg_len;

  hash_msg_feeder_if #(.DIGEST_W(32)) hif ();

  hash_msg_feeder #(
    .FIFO_DEPTH (16),
    .DIGEST_W   (32),
    .LEN_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .msg_close    (msg_close),
    .hash_start   (hash_start),
    .hif          (hif),
    .digest_out   (digest_out),
    .digest_valid (digest_valid),
    .msg_len      (msg_len)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned pushes   = 0;
  int unsigned cyc      = 0;
  logic [7:0]  rxq [$];
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_data = '0;
  logic        dr_seen   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already set; record what the coming edge will transfer, then advance to the next negedge.
  task automatic tick();
    #1;
    if (hold_pend) begin
      chk("dr_stable", hif.F_dr, 1'b1);
      chk("data_stable", hif.F_data, hold_data);
    end
    if (hif.End_of_File) chk("eof_with_dr", hif.F_dr, 1'b0);
    if (hif.F_dr) dr_seen = 1'b1;
    if (hif.F_dr && hif.F_rtr) rxq.push_back(hif.F_data);
    if (in_valid && in_ready) pushes++;
    hold_pend = hif.F_dr && !hif.F_rtr;
    hold_data = hif.F_data;
    @(negedge clk);
  endtask

  // Drain with F_rtr high one cycle in every 'period' until End_of_File or the budget runs out.
  task automatic wait_eof(input int unsigned period, input int unsigned budget);
    for (int unsigned k = 0; k < budget && !hif.End_of_File; k++) begin
      hif.F_rtr = ((cyc % period) == 0);
      tick();
      cyc++;
    end
    chk("eof_reached", hif.End_of_File, 1'b1);
    hif.F_rtr = 1'b0;
  endtask

  task automatic start_msg();
    go = 1'b1;
    tick();
    go = 1'b0;
    rxq.delete();
    pushes = 0;
  endtask

  task automatic finish_msg(input logic [31:0] dg);
    hif.H_ready   = 1'b1;
    hif.digest_in = dg;
    tick();
    hif.H_ready = 1'b0;
    chk("digest_out", digest_out, dg);
    chk("digest_valid", digest_valid, 1'b1);
    chk("eof_dropped", hif.End_of_File, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    go            = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    in_last       = 1'b0;
    msg_close     = 1'b0;
    hif.F_rtr     = 1'b0;
    hif.H_ready   = 1'b0;
    hif.digest_in = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_hash_start", hash_start, 1'b0);
    chk("rst_f_dr", hif.F_dr, 1'b0);
    chk("rst_f_data", hif.F_data, 8'h00);
    chk("rst_eof", hif.End_of_File, 1'b0);
    chk("rst_digest_valid", digest_valid, 1'b0);
    chk("rst_digest_out", digest_out, 32'h0);
    chk("rst_msg_len", msg_len, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: three bytes "abc", continuous F_rtr, digest capture
    start_msg();
    chk("t1_hash_start", hash_start, 1'b1);
    chk("t1_in_ready", in_ready, 1'b1);
    chk("t1_dr_empty", hif.F_dr, 1'b0);
    hif.F_rtr = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h61;
    tick();
    chk("t1_hash_start_pulse", hash_start, 1'b0);
    chk("t1_dr_after_push", hif.F_dr, 1'b1);
    chk("t1_first_byte", hif.F_data, 8'h61);
    in_data = 8'h62;
    tick();
    in_data = 8'h63;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t1_closed_in_ready", in_ready, 1'b0);
    cyc = 0;
    wait_eof(1, 20);
    chk("t1_count", rxq.size(), 3);
    if (rxq.size() == 3) begin
      chk("t1_b0", rxq[0], 8'h61);
      chk("t1_b1", rxq[1], 8'h62);
      chk("t1_b2", rxq[2], 8'h63);
    end
`ifdef HASH_FEED_LEN_CNT_EN
    chk("t1_msg_len", msg_len, 16'd3);
`else
    chk("t1_msg_len_tied", msg_len, 16'd0);
`endif
    // H_ready arriving a cycle late must keep End_of_File held
    tick();
    chk("t1_eof_held", hif.End_of_File, 1'b1);
    finish_msg(32'hDEADBEEF);

    // 2: five bytes, F_rtr one cycle in three
    start_msg();
    chk("t2_digest_valid_drop", digest_valid, 1'b0);
    cyc = 1;
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'h10 + 8'(i);
      in_last   = (i == 4);
      hif.F_rtr = ((cyc % 3) == 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_eof(3, 60);
    chk("t2_count", rxq.size(), 5);
    for (int unsigned i = 0; i < 5 && i < rxq.size(); i++)
      chk("t2_byte", rxq[i], 8'h10 + 8'(i));
    finish_msg(32'h12345678);

    // 3: overfill a 16-deep FIFO, then drain
    start_msg();
    for (int unsigned i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h20 + 8'(i);
      tick();
    end
    chk("t3_full_in_ready", in_ready, 1'b0);
    chk("t3_full_head", hif.F_data, 8'h20);
    chk("t3_full_pushes", pushes, 16);
    in_data   = 8'h30;
    in_last   = 1'b1;
    hif.F_rtr = 1'b1;
    for (int unsigned k = 0; k < 10 && pushes < 17; k++) tick();
    chk("t3_pushes", pushes, 17);
    in_valid = 1'b0;
    in_last  = 1'b0;
    cyc = 0;
    wait_eof(1, 40);
    chk("t3_count", rxq.size(), 17);
    for (int unsigned i = 0; i < 17 && i < rxq.size(); i++)
      chk("t3_byte", rxq[i], 8'h20 + 8'(i));
    finish_msg(32'hCAFEF00D);

    // 4: zero-length message
    start_msg();
    dr_seen   = 1'b0;
    msg_close = 1'b1;
    tick();
    msg_close = 1'b0;
    chk("t4_eof_not_yet", hif.End_of_File, 1'b0);
    chk("t4_in_ready_closed", in_ready, 1'b0);
    tick();
    chk("t4_eof", hif.End_of_File, 1'b1);
    chk("t4_no_dr", dr_seen, 1'b0);
    finish_msg(32'h0BADC0DE);

    // 5: async reset with five bytes buffered
    start_msg();
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("t5_buffered_dr", hif.F_dr, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    hold_pend = 1'b0;
    chk("t5_rst_f_dr", hif.F_dr, 1'b0);
    chk("t5_rst_f_data", hif.F_data, 8'h00);
    chk("t5_rst_eof", hif.End_of_File, 1'b0);
    chk("t5_rst_in_ready", in_ready, 1'b0);
    chk("t5_rst_digest_valid", digest_valid, 1'b0);
    chk("t5_rst_digest_out", digest_out, 32'h0);
    chk("t5_rst_msg_len", msg_len, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_msg();
    chk("t5_restart_empty", hif.F_dr, 1'b0);
    chk("t5_restart_in_ready", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    in_last   = 1'b1;
    hif.F_rtr = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    cyc = 0;
    wait_eof(1, 10);
    chk("t5_count", rxq.size(), 1);
    if (rxq.size() == 1) chk("t5_byte", rxq[0], 8'hA5);
    finish_msg(32'h55AA55AA);

`ifdef HASH_FEED_LEN_CNT_EN
    // 6: 300-byte message length count
    start_msg();
    hif.F_rtr = 1'b1;
    for (int unsigned i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      in_last  = (i == 299);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    cyc = 0;
    wait_eof(1, 20);
    chk("t6_count", rxq.size(), 300);
    chk("t6_msg_len", msg_len, 16'd300);
    finish_msg(32'h01020304);
    chk("t6_msg_len_hold", msg_len, 16'd300);
    start_msg();
    chk("t6_msg_len_clear", msg_len, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
